cskip_accum_32: RTL and testbench

- Registered streaming accumulator that consumes the team's 32-bit carry-skip adder (8-bit blocks; ports x1, x2, cin -> s, cout).
- Sums a burst of 32-bit unsigned operands delimited by a last flag.
- Presents the burst total, beat count and a sticky carry-out flag on a valid/ready output.
- Sits directly downstream of the operand source and wraps the combinational adder with a state machine, so adder timing is bounded by one register-to-register path.

---
 rtl/cskip_accum_32.sv | 162 ++++++++++++++++
 tb/tb_cskip_accum_32.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cskip_accum_32.sv
// Streaming burst accumulator built around a 32-bit carry-skip adder (8-bit skip blocks).
// Define CSKIP_ACCUM_SATURATE_EN to clamp the running sum at 32'hFFFFFFFF on carry-out.

module cskip_add_32 (
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  logic        cin,
   output logic [31:0] s,
   output logic        cout
);
   logic [31:0] p_s;
   logic [31:0] g_s;
   logic        c_s;
   logic        blk_c_s;

   assign p_s = x1 ^ x2;
   assign g_s = x1 & x2;

   // Ripple inside each 8-bit block; a fully propagating block forwards its carry-in directly.
   always_comb begin
      s       = 32'd0;
      c_s     = 1'b0;
      blk_c_s = cin;
      for (int b = 0; b < 4; b++) begin
         c_s = blk_c_s;
         for (int i = 0; i < 8; i++) begin
            s[8*b+i] = p_s[8*b+i] ^ c_s;
            c_s      = g_s[8*b+i] | (p_s[8*b+i] & c_s);
         end
         blk_c_s = (&p_s[8*b +: 8]) ? blk_c_s : c_s;
      end
      cout = blk_c_s;
   end
endmodule

module cskip_accum_32 #(
   parameter int   COUNT_W  = 8,
   parameter logic INIT_CIN = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_sum,
   output logic               out_ovf,
   output logic [COUNT_W-1:0] out_count
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
   localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

   logic [1:0]         state_q, state_d;
   logic [31:0]        acc_q, acc_d;
   logic               ovf_q, ovf_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_sum_q, out_sum_d;
   logic               out_ovf_q, out_ovf_d;
   logic [COUNT_W-1:0] out_count_q, out_count_d;

   logic        accept_s;
   logic        first_s;
   logic [31:0] x1_s;
   logic [31:0] x2_s;
   logic        cin_s;
   logic [31:0] sum_s;
   logic        cout_s;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt);
      if (cnt == CNT_MAX) begin
         return cnt;
      end else begin
         return cnt + CNT_ONE;
      end
   endfunction

   assign in_ready = (state_q != ST_HOLD) || out_ready;
   assign accept_s = in_valid && in_ready;
   assign first_s  = (state_q != ST_ACCUM);

   // Idle data lanes are forced to zero so an undriven operand never reaches the adder.
   assign x1_s  = first_s ? 32'd0 : acc_q;
   assign x2_s  = in_valid ? in_data : 32'd0;
   assign cin_s = first_s ? INIT_CIN : 1'b0;

   cskip_add_32 u_add (
      .x1  (x1_s),
      .x2  (x2_s),
      .cin (cin_s),
      .s   (sum_s),
      .cout(cout_s)
   );

   // Next-state: accumulate accepted beats, open/close bursts and retire results.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_ovf_d   = out_ovf_q;
      out_count_d = out_count_q;
      if (accept_s) begin
`ifdef CSKIP_ACCUM_SATURATE_EN
         acc_d = cout_s ? 32'hFFFF_FFFF : sum_s;
`else
         acc_d = sum_s;
`endif
         ovf_d       = (first_s ? 1'b0 : ovf_q) | cout_s;
         count_d     = first_s ? CNT_ONE : sat_inc(count_q);
         state_d     = in_last ? ST_HOLD : ST_ACCUM;
         out_valid_d = in_last;
         if (in_last) begin
            out_sum_d   = acc_d;
            out_ovf_d   = ovf_d;
            out_count_d = count_d;
         end else begin
            out_sum_d   = out_sum_q;
         end
      end else if ((state_q == ST_HOLD) && out_ready) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
      end else begin
         state_d     = state_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= 32'd0;
         ovf_q       <= 1'b0;
         count_q     <= {COUNT_W{1'b0}};
         out_valid_q <= 1'b0;
         out_sum_q   <= 32'd0;
         out_ovf_q   <= 1'b0;
         out_count_q <= {COUNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_ovf_q   <= out_ovf_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_ovf   = out_ovf_q;
   assign out_count = out_count_q;
endmodule

// File: tb/tb_cskip_accum_32.sv
// Scoreboard bench for cskip_accum_32: two instances (COUNT_W=8 and COUNT_W=2) share one stimulus stream.
module tb_cskip_accum_32;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready8, in_ready2;
   logic        out_valid8, out_valid2;
   logic [31:0] out_sum8, out_sum2;
   logic        out_ovf8, out_ovf2;
   logic [7:0]  out_count8;
   logic [1:0]  out_count2;

   always #5 clk = ~clk;

   cskip_accum_32 #(.COUNT_W(8), .INIT_CIN(1'b0)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
      .out_ovf(out_ovf8), .out_count(out_count8));

   cskip_accum_32 #(.COUNT_W(2), .INIT_CIN(1'b0)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
      .out_ovf(out_ovf2), .out_count(out_count2));

   typedef struct {
      logic [31:0] sum;
      logic        ovf;
      logic [31:0] cnt [2];
   } exp_t;

   exp_t   exp_q [$];
   int     rd [2];
   int     nvec = 0;
   int     nerr = 0;

   // Reference model state: whole-burst arithmetic with a wide total.
   logic [63:0] burst_total;
   int          burst_n;
   bit          in_burst;
   bit          pend;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t close_burst(input logic [63:0] total, input int n);
      exp_t e;
      e.ovf = (total[63:32] != 32'd0);
`ifdef CSKIP_ACCUM_SATURATE_EN
      e.sum = e.ovf ? 32'hFFFF_FFFF : total[31:0];
`else
      e.sum = total[31:0];
`endif
      e.cnt[0] = (n > 255) ? 32'd255 : n;
      e.cnt[1] = (n > 3) ? 32'd3 : n;
      return e;
   endfunction

   task automatic beat(input bit v, input logic [31:0] d, input bit l, input bit r);
      bit exp_ready;
      bit acc;
      @(posedge clk);
      #2;
      in_valid  = v;
      in_data   = v ? d : 32'hxxxx_xxxx;
      in_last   = l;
      out_ready = r;
      exp_ready = !pend || r;
      #1;
      check("in_ready8", {31'd0, in_ready8}, {31'd0, exp_ready});
      check("in_ready2", {31'd0, in_ready2}, {31'd0, exp_ready});
      acc = v && exp_ready;
      if (acc) begin
         if (!in_burst) begin
            burst_total = {32'd0, d};
            burst_n     = 1;
         end else begin
            burst_total = burst_total + {32'd0, d};
            burst_n     = burst_n + 1;
         end
         in_burst = !l;
         if (l) exp_q.push_back(close_burst(burst_total, burst_n));
      end
      if (acc && l) pend = 1'b1;
      else if (pend && r) pend = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(posedge clk);
      #2;
      rst      = 1'b0;
      in_burst = 1'b0;
      pend     = 1'b0;
      rd[0]    = exp_q.size();
      rd[1]    = exp_q.size();
   endtask

   // Monitor: pop on every newly presented result, verify held results stay stable.
   logic        mon_v   [2];
   logic [31:0] mon_sum [2];
   logic        mon_ovf [2];
   logic [31:0] mon_cnt [2];
   bit          prev_v  [2];
   exp_t        cur     [2];

   assign mon_v[0] = out_valid8;   assign mon_v[1] = out_valid2;
   assign mon_sum[0] = out_sum8;   assign mon_sum[1] = out_sum2;
   assign mon_ovf[0] = out_ovf8;   assign mon_ovf[1] = out_ovf2;
   assign mon_cnt[0] = {24'd0, out_count8};
   assign mon_cnt[1] = {30'd0, out_count2};

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            prev_v[k] = 1'b0;
         end else begin
            if (mon_v[k] === 1'b1) begin
               if (!prev_v[k] || out_ready) begin
                  if (rd[k] >= exp_q.size()) begin
                     nvec++;
                     nerr++;
                     $display("FAIL spurious_out_valid[%0d]: got 1 expected 0 at %0t", k, $time);
                  end else begin
                     cur[k] = exp_q[rd[k]];
                     rd[k]++;
                     check($sformatf("out_sum[%0d]", k), mon_sum[k], cur[k].sum);
                     check($sformatf("out_ovf[%0d]", k), {31'd0, mon_ovf[k]}, {31'd0, cur[k].ovf});
                     check($sformatf("out_count[%0d]", k), mon_cnt[k], cur[k].cnt[k]);
                  end
               end else begin
                  check($sformatf("held_sum[%0d]", k), mon_sum[k], cur[k].sum);
                  check($sformatf("held_ovf[%0d]", k), {31'd0, mon_ovf[k]}, {31'd0, cur[k].ovf});
                  check($sformatf("held_count[%0d]", k), mon_cnt[k], cur[k].cnt[k]);
               end
            end
            prev_v[k] = (mon_v[k] === 1'b1);
         end
      end
   end

   initial begin
      burst_total = 64'd0;
      burst_n = 0;
      in_burst = 1'b0;
      pend = 1'b0;
      rd[0] = 0;
      rd[1] = 0;
      do_reset();
      #1;
      check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
      check("rst_out_sum", out_sum8, 32'd0);
      check("rst_out_ovf", {31'd0, out_ovf8}, 32'd0);
      check("rst_out_count", {24'd0, out_count8}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready8}, 32'd1);

      // Single beat, then a three-beat burst with a gap.
      beat(1'b1, 32'h5, 1'b1, 1'b1);
      beat(1'b1, 32'h10, 1'b0, 1'b1);
      beat(1'b0, 32'h0, 1'b0, 1'b1);
      beat(1'b1, 32'h20, 1'b0, 1'b1);
      beat(1'b1, 32'h30, 1'b1, 1'b1);
      // Overflow.
      beat(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      beat(1'b1, 32'h2, 1'b1, 1'b1);
      // Backpressure with a blocked beat, then overlapped retire and new burst.
      beat(1'b1, 32'h11, 1'b1, 1'b1);
      beat(1'b0, 32'h0, 1'b0, 1'b0);
      beat(1'b1, 32'h99, 1'b1, 1'b0);
      beat(1'b0, 32'h0, 1'b0, 1'b0);
      beat(1'b1, 32'h7, 1'b1, 1'b1);
      beat(1'b0, 32'h0, 1'b0, 1'b1);
      // Reset mid-burst.
      beat(1'b1, 32'h1, 1'b0, 1'b1);
      beat(1'b1, 32'h2, 1'b0, 1'b1);
      do_reset();
      beat(1'b1, 32'h3, 1'b1, 1'b1);
      // Count saturation on the narrow instance.
      for (int i = 0; i < 5; i++) beat(1'b1, 32'h1, (i == 4), 1'b1);
      beat(1'b0, 32'h0, 1'b0, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            beat(($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) == 0) ? $urandom : {24'd0, 8'($urandom)},
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 6));
         end
      end

      for (int i = 0; i < 4; i++) beat(1'b0, 32'h0, 1'b0, 1'b1);
      check("drain8", rd[0], exp_q.size());
      check("drain2", rd[1], exp_q.size());
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
